// File: rtl/sensor_timer_pkg.sv
// Shared types and default constants for the sensor timer scheduler.
// Consumers import sensor_timer_pkg::*.
package sensor_timer_pkg;

    localparam int unsigned DEF_CLOCK_FREQ = 100_000_000;
    localparam int unsigned DEF_TICK_FREQ  = 1_000_000;
    localparam int unsigned DEF_CNT_W      = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV cycles.
// A clear restarts the count so the next tick lands DIV cycles later.
module us_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pcnt_q, pcnt_d;

    assign tick = (pcnt_q == PW'(DIV - 1));

    always_comb begin
        if (clear || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/sensor_timer_sched.sv
// Round-robin scheduler sharing one tick-based delay timer among requesters.
// Define SCHED_STATUS_EN to expose the live counter on port remain.
module sensor_timer_sched
    import sensor_timer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = DEF_CLOCK_FREQ,
    parameter int unsigned TICK_FREQ  = DEF_TICK_FREQ,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] delay,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
`ifdef SCHED_STATUS_EN
    ,
    output logic [CNT_W-1:0]         remain
`endif
);

    localparam int unsigned DIV = CLOCK_FREQ / TICK_FREQ;
    localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dsel;
    logic [IW-1:0]   win;
    logic            found;
    logic            load;
    logic            tick;

    us_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(load),
        .tick (tick)
    );

    // Search starts one past the last granted slot.
    always_comb begin : arb
        logic [IW-1:0] cand;
        cand  = '0;
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IW'((int'(last_q) + k) % int'(NUM_REQ));
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        dsel = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win == IW'(i)) begin
                dsel = delay[i*CNT_W +: CNT_W];
            end
        end
    end

    assign load = (state_q == IDLE) && found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) state_d = RUN;
            end
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == '0 ||
                             (tick && cnt_q == CNT_W'(1))) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (load) begin
            owner_d = win;
            last_d  = win;
            cnt_d   = dsel;
        end else if (state_q == RUN) begin
            if (!req[owner_q]) begin
                cnt_d = '0;
            end else if (tick && cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Grant drops in the same cycle the done pulse is presented.
    always_comb begin
        grant = '0;
        done  = '0;
        if (state_q == RUN) begin
            grant[owner_q] = 1'b1;
        end
        if (state_q == FINISH) begin
            done[owner_q] = 1'b1;
        end
        busy = (state_q == RUN);
    end

`ifdef SCHED_STATUS_EN
    assign remain = cnt_q;
`endif

endmodule

// File: tb/tb_sensor_timer_sched.sv
// Scoreboard bench for sensor_timer_sched at DIV = 100.
// Expected grant/done transitions are queued by stimulus and popped by a monitor.
module tb_sensor_timer_sched;

    localparam int DIV   = 100;
    localparam int CNT_W = 20;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req   = '0;
    logic [39:0] delay = '0;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        busy;
`ifdef SCHED_STATUS_EN
    logic [CNT_W-1:0] remain;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    typedef struct {
        logic [1:0] g;
        logic [1:0] d;
        longint     c;
    } ev_t;

    ev_t q[$];

    sensor_timer_sched dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .delay(delay),
        .grant(grant),
        .done (done),
        .busy (busy)
`ifdef SCHED_STATUS_EN
        ,
        .remain(remain)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    logic [3:0] prev = '0;

    always @(negedge clk) begin
        ev_t e;
        if ({grant, done} != prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d grant=%b done=%b",
                         cyc, grant, done);
            end else begin
                e = q.pop_front();
                if (e.g !== grant || e.d !== done || e.c != cyc) begin
                    errors++;
                    $display("FAIL event actual grant=%b done=%b cyc=%0d required grant=%b done=%b cyc=%0d",
                             grant, done, cyc, e.g, e.d, e.c);
                end
            end
            prev = {grant, done};
        end
        checks++;
        if (busy !== (grant != 2'b00)) begin
            errors++;
            $display("FAIL busy cyc=%0d actual=%b grant=%b", cyc, busy, grant);
        end
    end

    task automatic check(string n, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", n, cyc, act, exp);
        end
    endtask

    task automatic push(logic [1:0] g, logic [1:0] d, longint c);
        ev_t e;
        e.g = g;
        e.d = d;
        e.c = c;
        q.push_back(e);
    endtask

    function automatic longint fin(longint g, int d);
        return (d == 0) ? g + 1 : g + longint'(d) * DIV;
    endfunction

    task automatic job(int s, longint g, int d);
        logic [1:0] oh;
        oh = 2'b01 << s;
        push(oh, 2'b00, g);
        push(2'b00, oh, fin(g, d));
        push(2'b00, 2'b00, fin(g, d) + 1);
    endtask

    task automatic wait_until(longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(int s, int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done[s]) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", longint'(seen), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    longint g, g1, f0;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_grant", longint'(grant), 0);
        check("rst_done", longint'(done), 0);
        check("rst_busy", longint'(busy), 0);
`ifdef SCHED_STATUS_EN
        check("rst_remain", longint'(remain), 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Long slot-0 delay while slot 1 toggles its request.
        delay[19:0] = 20'd150;
        req = 2'b01;
        g = cyc + 1;
        job(0, g, 150);
        wait_until(g + 1000);
        req[1] = 1'b1;
        delay[39:20] = 20'd7;
        wait_until(g + 5000);
        req[1] = 1'b0;
        wait_until(g + 9000);
        req[1] = 1'b1;
        wait_until(g + 9050);
        req[1] = 1'b0;
        wait_done(0, 20000);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Both request out of reset: slot 0 first, slot 1 after an idle cycle.
        do_reset();
        delay = {20'd2, 20'd3};
        req = 2'b11;
        g = cyc + 1;
        job(0, g, 3);
        g1 = fin(g, 3) + 2;
        job(1, g1, 2);
        wait_done(0, 1000);
        req[0] = 1'b0;
        wait_done(1, 1000);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Owner drops request mid-run.
        delay[39:20] = 20'd10;
        req = 2'b10;
        g = cyc + 1;
        push(2'b10, 2'b00, g);
        wait_until(g + 500);
        req[1] = 1'b0;
        push(2'b00, 2'b00, g + 501);
        repeat (1200) @(negedge clk);
        check("abort_busy", longint'(busy), 0);

        // Pointer past slot 1: slot 0 (D=1) then slot 1 (D=0).
        delay = {20'd0, 20'd1};
        req = 2'b11;
        g = cyc + 1;
        job(0, g, 1);
        g1 = fin(g, 1) + 2;
        job(1, g1, 0);
        wait_done(0, 500);
        req[0] = 1'b0;
        wait_done(1, 500);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a 10-tick run, then restart.
        delay[19:0] = 20'd10;
        req = 2'b01;
        g = cyc + 1;
        push(2'b01, 2'b00, g);
        wait_until(g + 300);
        #1 reset = 1'b0;
        #1;
        check("midrst_grant", longint'(grant), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_busy", longint'(busy), 0);
        push(2'b00, 2'b00, g + 301);
        req = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req = 2'b01;
        g = cyc + 1;
        job(0, g, 10);
        wait_done(0, 2000);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Five-tick run, counter visible when status is built in.
        delay[19:0] = 20'd5;
        req = 2'b01;
        g = cyc + 1;
        job(0, g, 5);
`ifdef SCHED_STATUS_EN
        for (int k = 0; k < 5; k++) begin
            wait_until(g + k * DIV);
            check("remain", longint'(remain), 5 - k);
        end
`endif
        wait_done(0, 1000);
        req[0] = 1'b0;
        f0 = cyc;
        check("done_cycle", f0, g + 500);
`ifdef SCHED_STATUS_EN
        check("remain_fin", longint'(remain), 0);
        @(negedge clk);
        check("remain_idle", longint'(remain), 0);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", longint'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
